// File: rtl/access_sequencer_pkg.sv
// Shared room-security types and defaults: sequencer state encoding, default code width and password.
// Pure declarations; no timing or flow-control behaviour of its own.
package room_security_pkg;

    localparam int                          DEFAULT_CODE_W       = 4;
    localparam logic [DEFAULT_CODE_W-1:0]   DEFAULT_CORRECT_CODE = 4'b1010;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/access_sequencer_if.sv
// Keypad-side request bus and door/alarm status outputs of the access sequencer.
// Keypads hold req with a stable code until they see their one-cycle ack.
interface access_sequencer_if #(
    parameter int NUM_KEYPADS = 4,
    parameter int CODE_W      = 4
);
    logic [NUM_KEYPADS-1:0]        req;
    logic [NUM_KEYPADS*CODE_W-1:0] code;
    logic [NUM_KEYPADS-1:0]        ack;
    logic                          pass;
    logic                          door_lock;
    logic                          alarm;
    logic                          locked_out;

    modport master (
        output req, code,
        input  ack, pass, door_lock, alarm, locked_out
    );

    modport slave (
        input  req, code,
        output ack, pass, door_lock, alarm, locked_out
    );
endinterface

// File: rtl/access_sequencer_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping to bit 0.
// Zero latency; unserved requesters simply keep their request asserted.
module rr_arbiter #(
    parameter int NUM_KEYPADS = 4,
    parameter int IDW         = $clog2(NUM_KEYPADS)
) (
    input  logic [NUM_KEYPADS-1:0] i_req,
    input  logic [IDW-1:0]         i_ptr,
    output logic [NUM_KEYPADS-1:0] o_grant,
    output logic [IDW-1:0]         o_id,
    output logic                   o_any
);

    always_comb begin
        o_grant = '0;
        o_id    = '0;
        o_any   = 1'b0;
        // Upper segment first (pointer and above), then wrap to the lower segment.
        for (int i = 0; i < NUM_KEYPADS; i++) begin
            if (!o_any && i_req[i] && (i >= int'(i_ptr))) begin
                o_any      = 1'b1;
                o_grant[i] = 1'b1;
                o_id       = IDW'(i);
            end
        end
        for (int i = 0; i < NUM_KEYPADS; i++) begin
            if (!o_any && i_req[i]) begin
                o_any      = 1'b1;
                o_grant[i] = 1'b1;
                o_id       = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/access_sequencer.sv
// Room lock sequencer: round-robin keypad grant, code check, timed unlock, alarm lockout (ALARM_LATCH_EN holds alarm past lockout).
// Ack two clocks after an uncontended req; requests wait unserved while unlocked or locked out.
module access_sequencer
    import room_security_pkg::*;
#(
    parameter int                NUM_KEYPADS    = 4,
    parameter int                CODE_W         = DEFAULT_CODE_W,
    parameter logic [CODE_W-1:0] CORRECT_CODE   = DEFAULT_CORRECT_CODE,
    parameter int                MAX_FAILS      = 3,
    parameter int                UNLOCK_CYCLES  = 8,
    parameter int                LOCKOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              clear_n,
    access_sequencer_if.slave bus
);

    localparam int IDW = $clog2(NUM_KEYPADS);
    localparam int FW  = $clog2(MAX_FAILS + 1);
    localparam int TW  = $clog2(max_int(UNLOCK_CYCLES, LOCKOUT_CYCLES) + 1);

    seq_state_t              r_state;
    logic [IDW-1:0]          r_ptr;
    logic [IDW-1:0]          r_id;
    logic [CODE_W-1:0]       r_code;
    logic [FW-1:0]           r_fails;
    logic [TW-1:0]           r_timer;
    logic [NUM_KEYPADS-1:0]  r_ack;
    logic                    r_pass;
    logic                    r_door_lock;
    logic                    r_alarm;
    logic                    r_locked_out;

    seq_state_t              w_state_nxt;
    logic [IDW-1:0]          w_ptr_nxt;
    logic [IDW-1:0]          w_id_nxt;
    logic [CODE_W-1:0]       w_code_nxt;
    logic [FW-1:0]           w_fails_nxt;
    logic [TW-1:0]           w_timer_nxt;
    logic [NUM_KEYPADS-1:0]  w_ack_nxt;
    logic                    w_pass_nxt;
    logic                    w_door_lock_nxt;
    logic                    w_alarm_nxt;
    logic                    w_locked_out_nxt;

    logic [NUM_KEYPADS-1:0]  w_req_open;
    logic [NUM_KEYPADS-1:0]  w_grant;
    logic [IDW-1:0]          w_grant_id;
    logic                    w_grant_any;
    logic [CODE_W-1:0]       w_sel_code;
    logic [FW-1:0]           w_fails_inc;

    // A requester may still hold req during its own ack cycle; that is not a new attempt.
    assign w_req_open = bus.req & ~r_ack;

    rr_arbiter #(
        .NUM_KEYPADS (NUM_KEYPADS),
        .IDW         (IDW)
    ) u_arb (
        .i_req   (w_req_open),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_id    (w_grant_id),
        .o_any   (w_grant_any)
    );

    always_comb begin
        w_sel_code = '0;
        for (int i = 0; i < NUM_KEYPADS; i++) begin
            if (w_grant[i]) begin
                w_sel_code = bus.code[i*CODE_W +: CODE_W];
            end
        end
    end

    assign w_fails_inc = (r_fails == FW'(MAX_FAILS)) ? r_fails : r_fails + 1'b1;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_id         <= '0;
            r_code       <= '0;
            r_fails      <= '0;
            r_timer      <= '0;
            r_ack        <= '0;
            r_pass       <= 1'b0;
            r_door_lock  <= 1'b1;
            r_alarm      <= 1'b0;
            r_locked_out <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_id         <= w_id_nxt;
            r_code       <= w_code_nxt;
            r_fails      <= w_fails_nxt;
            r_timer      <= w_timer_nxt;
            r_ack        <= w_ack_nxt;
            r_pass       <= w_pass_nxt;
            r_door_lock  <= w_door_lock_nxt;
            r_alarm      <= w_alarm_nxt;
            r_locked_out <= w_locked_out_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_id_nxt         = r_id;
        w_code_nxt       = r_code;
        w_fails_nxt      = r_fails;
        w_timer_nxt      = r_timer;
        w_ack_nxt        = '0;
        w_pass_nxt       = 1'b0;
        w_door_lock_nxt  = r_door_lock;
        w_alarm_nxt      = r_alarm;
        w_locked_out_nxt = r_locked_out;

        case (r_state)
            IDLE: begin
                if (w_grant_any) begin
                    w_id_nxt    = w_grant_id;
                    w_code_nxt  = w_sel_code;
                    w_state_nxt = CHECK;
                end
            end

            CHECK: begin
                w_ack_nxt[r_id] = 1'b1;
                w_ptr_nxt       = (r_id == IDW'(NUM_KEYPADS - 1)) ? '0 : r_id + 1'b1;
                if (r_code == CORRECT_CODE) begin
                    w_pass_nxt      = 1'b1;
                    w_door_lock_nxt = 1'b0;
                    w_fails_nxt     = '0;
                    w_alarm_nxt     = 1'b0;
                    w_timer_nxt     = TW'(UNLOCK_CYCLES - 1);
                    w_state_nxt     = UNLOCKED;
                end else begin
                    w_fails_nxt = w_fails_inc;
                    if (w_fails_inc == FW'(MAX_FAILS)) begin
                        w_alarm_nxt      = 1'b1;
                        w_locked_out_nxt = 1'b1;
                        w_timer_nxt      = TW'(LOCKOUT_CYCLES - 1);
                        w_state_nxt      = LOCKOUT;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end

            UNLOCKED: begin
                if (r_timer == '0) begin
                    w_door_lock_nxt = 1'b1;
                    w_state_nxt     = IDLE;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end

            LOCKOUT: begin
                if (r_timer == '0) begin
                    w_locked_out_nxt = 1'b0;
                    w_fails_nxt      = '0;
`ifdef ALARM_LATCH_EN
                    w_alarm_nxt      = r_alarm;
`else
                    w_alarm_nxt      = 1'b0;
`endif
                    w_state_nxt      = IDLE;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.ack        = r_ack;
    assign bus.pass       = r_pass;
    assign bus.door_lock  = r_door_lock;
    assign bus.alarm      = r_alarm;
    assign bus.locked_out = r_locked_out;

endmodule

// File: tb/tb_access_sequencer.sv
// Bench for access_sequencer: hand-built vector table, scripted corner cases and random traffic against an event-time model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_access_sequencer;

    localparam int           N   = 4;
    localparam int           W   = 4;
    localparam int           U   = 8;
    localparam int           L   = 16;
    localparam int           MF  = 3;
    localparam logic [W-1:0] CC  = 4'b1010;
    localparam logic [W-1:0] BAD = 4'b0011;
    localparam logic [7:0]   RST = 8'h04;
`ifdef ALARM_LATCH_EN
    localparam bit           LATCH = 1'b1;
`else
    localparam bit           LATCH = 1'b0;
`endif

    logic clock = 1'b0;
    logic clear_n;
    always #5 clock = ~clock;

    access_sequencer_if #(.NUM_KEYPADS(N), .CODE_W(W)) bus ();

    access_sequencer #(
        .NUM_KEYPADS    (N),
        .CODE_W         (W),
        .CORRECT_CODE   (CC),
        .MAX_FAILS      (MF),
        .UNLOCK_CYCLES  (U),
        .LOCKOUT_CYCLES (L)
    ) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the clock-edge numbers at which events are due rather than a state machine.
    int           m_edge, m_judge_edge, m_next_sample, m_relock_edge, m_lock_end_edge;
    int           m_fails, m_ptr, m_id;
    logic [W-1:0] m_code;
    logic [N-1:0] m_ack;
    logic         m_pass, m_door, m_alarm, m_lo;

    function automatic void model_reset();
        m_edge = 0; m_judge_edge = -1; m_next_sample = 0;
        m_relock_edge = -1; m_lock_end_edge = -1;
        m_fails = 0; m_ptr = 0; m_id = 0; m_code = '0;
        m_ack = '0; m_pass = 1'b0; m_door = 1'b1; m_alarm = 1'b0; m_lo = 1'b0;
    endfunction

    function automatic void model_edge(input logic [N-1:0] r, input logic [N*W-1:0] c);
        logic [N-1:0] open_req;
        bit           found;
        open_req = r & ~m_ack;
        found    = 1'b0;
        m_ack    = '0;
        m_pass   = 1'b0;
        if (m_edge == m_relock_edge) m_door = 1'b1;
        if (m_edge == m_lock_end_edge) begin
            m_lo    = 1'b0;
            m_fails = 0;
            if (!LATCH) m_alarm = 1'b0;
        end
        if (m_edge == m_judge_edge) begin
            m_ack = N'(1) << m_id;
            m_ptr = (m_id + 1) % N;
            if (m_code == CC) begin
                m_pass = 1'b1; m_door = 1'b0; m_fails = 0; m_alarm = 1'b0;
                m_relock_edge = m_edge + U;
                m_next_sample = m_edge + U + 1;
            end else begin
                m_fails++;
                if (m_fails >= MF) begin
                    m_alarm = 1'b1; m_lo = 1'b1;
                    m_lock_end_edge = m_edge + L;
                    m_next_sample   = m_edge + L + 1;
                end else begin
                    m_next_sample = m_edge + 1;
                end
            end
        end else if (m_edge >= m_next_sample) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (!found && open_req[idx]) begin
                    found        = 1'b1;
                    m_id         = idx;
                    m_code       = c[idx*W +: W];
                    m_judge_edge = m_edge + 1;
                    m_next_sample = m_edge + 2;
                end
            end
        end
        m_edge++;
    endfunction

    function automatic logic [7:0] outs();
        return {bus.ack, bus.pass, bus.door_lock, bus.alarm, bus.locked_out};
    endfunction

    task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] c);
        bus.req  = r;
        bus.code = c;
        model_edge(r, c);
        @(posedge clock);
        @(negedge clock);
        chk("cycle_vs_model", outs(), {m_ack, m_pass, m_door, m_alarm, m_lo});
    endtask

    task automatic do_reset();
        clear_n  = 1'b0;
        bus.req  = '0;
        bus.code = '0;
        repeat (2) @(negedge clock);
        chk("reset_state", outs(), RST);
        model_reset();
        clear_n = 1'b1;
    endtask

    // Raises req for one keypad and returns on the cycle its ack is visible (req still high then).
    task automatic submit(input int kp, input logic [W-1:0] cd, output logic ok_pass);
        logic [N-1:0]   r;
        logic [N*W-1:0] c;
        bit             seen;
        r       = N'(1) << kp;
        c       = (N*W)'(cd) << (kp * W);
        seen    = 1'b0;
        ok_pass = 1'b0;
        for (int t = 0; t < 60 && !seen; t++) begin
            step(r, c);
            if (bus.ack == r) begin
                seen    = 1'b1;
                ok_pass = bus.pass;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL submit_timeout: keypad %0d got no ack, required one within 60 cycles", kp);
        end
    endtask

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] code;
        logic [7:0]     exp;
    } vec_t;

    vec_t vt[13];
    int   order[$];
    int   exp_order[4] = '{0, 1, 2, 3};

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at %0t, required completion earlier", $time);
        $fatal(1);
    end

    initial begin
        logic           p;
        int             lo_cnt;
        bit             seen_end, served;
        logic           alarm_after;
        logic [N-1:0]   r;
        logic [N*W-1:0] c;

        // Keypad 2 passes, door open for U clocks, then keypad 0 fails once.
        vt[0] = '{4'b0100, 16'h0A00, 8'h04};
        vt[1] = '{4'b0100, 16'h0A00, 8'h48};
        for (int i = 2; i <= 8; i++) vt[i] = '{4'b0000, 16'h0000, 8'h00};
        vt[9]  = '{4'b0000, 16'h0000, 8'h04};
        vt[10] = '{4'b0001, 16'h0003, 8'h04};
        vt[11] = '{4'b0001, 16'h0003, 8'h14};
        vt[12] = '{4'b0000, 16'h0000, 8'h04};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(vt[i].req, vt[i].code);
            chk($sformatf("vec%0d", i), outs(), vt[i].exp);
        end

        // Three failures -> alarm and lockout; a held request waits it out.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            submit(0, BAD, p);
            chk($sformatf("bad_pass%0d", k), p, 0);
            if (k < 2) step('0, '0);
        end
        chk("alarm_on_third", bus.alarm, 1);
        chk("lockout_on_third", bus.locked_out, 1);
        lo_cnt = 1; seen_end = 1'b0; served = 1'b0; alarm_after = 1'b0; p = 1'b0;
        for (int t = 0; t < 40 && !served; t++) begin
            step(4'b0010, 16'h00A0);
            if (bus.locked_out) lo_cnt++;
            else if (!seen_end) begin
                seen_end    = 1'b1;
                alarm_after = bus.alarm;
            end
            if (bus.ack == 4'b0010) begin
                served = 1'b1;
                p      = bus.pass;
            end
        end
        chk("lockout_len", lo_cnt, L);
        chk("alarm_after_lockout", alarm_after, LATCH);
        chk("held_req_served", served, 1);
        chk("held_req_pass", p, 1);
        chk("alarm_cleared_by_pass", bus.alarm, 0);
        step('0, '0);

        // All keypads contend with wrong codes from reset.
        do_reset();
        order.delete();
        for (int t = 0; t < 80 && order.size() < 4; t++) begin
            step(4'b1111, 16'h3333);
            for (int i = 0; i < N; i++) if (bus.ack[i]) order.push_back(i);
        end
        chk("order_count", order.size(), 4);
        for (int i = 0; i < 4; i++)
            if (order.size() > i) chk($sformatf("order%0d", i), order[i], exp_order[i]);
        step('0, '0);

        // A pass in between clears the failure streak.
        do_reset();
        submit(0, BAD, p); step('0, '0);
        submit(1, BAD, p); step('0, '0);
        submit(2, CC, p);
        chk("mid_pass", p, 1);
        repeat (U + 2) step('0, '0);
        submit(3, BAD, p); step('0, '0);
        submit(0, BAD, p);
        chk("no_alarm_after_pass", {bus.alarm, bus.locked_out}, 2'b00);
        step('0, '0);
        submit(1, BAD, p);
        chk("alarm_at_max", {bus.alarm, bus.locked_out}, 2'b11);

        // Asynchronous clear while in CHECK and while unlocked.
        do_reset();
        step(4'b0100, 16'h0A00);
        #2 clear_n = 1'b0;
        #1 chk("rst_async_check", outs(), RST);
        bus.req = '0;
        @(posedge clock);
        #1 chk("rst_no_ack", outs(), RST);
        @(negedge clock);
        model_reset();
        clear_n = 1'b1;
        submit(1, CC, p);
        chk("pass_kp1", p, 1);
        repeat (3) step('0, '0);
        chk("door_open_before_rst", bus.door_lock, 0);
        #2 clear_n = 1'b0;
        #1 chk("rst_async_unlocked", outs(), RST);
        @(negedge clock);
        model_reset();
        clear_n = 1'b1;
        repeat (3) step('0, '0);
        submit(0, CC, p);
        chk("pass_after_rst", p, 1);

        // Random traffic: requests held until acked, occasionally held past ack as a retry.
        do_reset();
        r = '0;
        c = '0;
        for (int t = 0; t < 800; t++) begin
            for (int i = 0; i < N; i++) begin
                if (r[i]) begin
                    if (bus.ack[i] && ($urandom_range(3, 0) != 0)) r[i] = 1'b0;
                end else if ($urandom_range(5, 0) == 0) begin
                    r[i] = 1'b1;
                    c[i*W +: W] = ($urandom_range(2, 0) == 0) ? CC : W'($urandom);
                end
            end
            step(r, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/access_sequencer.md
# access_sequencer

Front-end controller for the room lock: arbitrates password submissions from up to NUM_KEYPADS keypads onto a single code comparator, then sequences the door. The door relocks automatically after a timed unlock window. Repeated failures raise the alarm and force a timed lockout. Sits between the keypad interfaces and the door actuator/alarm drivers.

## Interface
- NUM_KEYPADS, 4: number of requesting keypads (2..8)
- CODE_W, 4: password width in bits
- CORRECT_CODE, 4'b1010: accepted password
- MAX_FAILS, 3: consecutive failures that trigger the alarm and lockout (1..7)
- UNLOCK_CYCLES, 8: clocks the door stays unlocked after a pass (>=1)
- LOCKOUT_CYCLES, 16: clocks requests are refused after the alarm triggers (>=1)
- clock  in  1  system clock, rising edge
- clear_n  in  1  asynchronous active-low reset
- req  in  NUM_KEYPADS  per-keypad submit request, level, held until ack
- code  in  NUM_KEYPADS*CODE_W  packed codes, keypad i at [i*CODE_W +: CODE_W], stable while req[i]
- ack  out  NUM_KEYPADS  one-hot, one-cycle pulse: keypad's attempt has been judged
- pass  out  1  valid with ack: 1 = correct code
- door_lock  out  1  1 = locked
- alarm  out  1  1 = alarm active
- locked_out  out  1  1 = in lockout; requests are not serviced

## Operation
- Reset values: ack=0, pass=0, door_lock=1, alarm=0, locked_out=0, fail count=0, round-robin pointer=0, state IDLE.
- States: IDLE, CHECK, UNLOCKED, LOCKOUT. All outputs are registered.
- IDLE: if any unmasked req is set, grant the first set bit searching upward from the pointer, wrapping around. Latch the grant id and its code, then go to CHECK. req[i] is masked in the cycle where ack[i]=1.
- CHECK, latched code == CORRECT_CODE:
  - ack[id]=1, pass=1, door_lock=0, fail count=0, alarm=0
  - load timer with UNLOCK_CYCLES-1, go to UNLOCKED
- CHECK, wrong code:
  - ack[id]=1, pass=0, fail count+1
  - If the new count == MAX_FAILS: alarm=1, locked_out=1, load timer with LOCKOUT_CYCLES-1, go to LOCKOUT.
  - Otherwise go to IDLE.
- In either CHECK outcome, pointer = (id+1) mod NUM_KEYPADS.
- UNLOCKED: the timer decrements each clock. When it is at 0, set door_lock=1 and go to IDLE. Requests wait (no ack).
- LOCKOUT: the timer decrements each clock. When it is at 0, set locked_out=0, fail count=0, and alarm=0 (see Configuration), then go to IDLE. Requests wait.
- Fail count saturates at MAX_FAILS, width $clog2(MAX_FAILS+1). Timer width is $clog2 of max(UNLOCK_CYCLES, LOCKOUT_CYCLES)+1.
- Failures are consecutive across all keypads; any pass clears the count.

## Timing
- req[i] sampled high at edge E0 in IDLE → ack[i], pass, and door_lock/alarm updates are visible after E1. Two-cycle latency when uncontended.
- ack is exactly one cycle wide. The requester drops req at or before the edge following ack; a req still high two edges after ack counts as a new attempt.
- door_lock is low for exactly UNLOCK_CYCLES clocks. locked_out is high for exactly LOCKOUT_CYCLES clocks.
- Simultaneous requests: one grant per CHECK. The next grant is evaluated in the first IDLE cycle afterwards.
- clear_n asserted mid-operation: immediate return to reset values. A pending ack is dropped and the requester must resubmit.

## Configuration
- ALARM_LATCH_EN defined: alarm is not cleared at lockout expiry. It stays 1 until a subsequent correct code (CHECK pass) or reset.
- Not defined: alarm clears when LOCKOUT expires.
- locked_out behaviour is identical in both builds.

## Structure
- Shared package room_security_pkg holds:
  - state enum seq_state_t {IDLE, CHECK, UNLOCKED, LOCKOUT}
  - default CORRECT_CODE constant
  - CODE_W default
- One sub-module, rr_arbiter: parameterised NUM_KEYPADS round-robin picker (req, pointer → one-hot grant, grant id, any). Purely combinational; the pointer register stays in access_sequencer.

## Test plan
- Reset, then keypad 2 submits 1010 → ack[2] after 2 clocks with pass=1; door_lock=0 for exactly 8 clocks, then returns to 1.
- Keypad 0 submits 0011 three times → pass=0 on each. Third ack: alarm=1 and locked_out=1 for 16 clocks; a req held during that time gets no ack; afterwards alarm=0 (macro off) and the held req is served.
- Same sequence with ALARM_LATCH_EN → alarm stays 1 after lockout; next 1010 → pass=1 and alarm=0.
- All four keypads hold req=1 with wrong codes from reset → acks in order 0,1,2; lockout starts; after lockout, keypad 3 is served before 0.
- Two wrong codes, then 1010 from another keypad, then two wrong codes → no alarm (count cleared by the pass).
- clear_n pulsed low while in CHECK and again while in UNLOCKED → outputs return to reset values asynchronously with no ack pulse; door_lock=1 immediately.
